fpu_arbiter: RTL and testbench

Issue arbiter and in-flight tracker for the shared, fully pipelined FPU in the execution stage. Two requesters present FP operations with a valid/ready handshake. The block grants at most one per cycle, round-robin, and drives the FPU operand registers. It tags each in-flight operation with owner and destination register, and returns each result to its owner exactly once, LATENCY+1 edges after acceptance. A per-requester flush kills that requester's in-flight operations.

---
 rtl/fpu_arbiter_if.sv | 50 +++++
 rtl/fpu_arbiter.sv | 109 ++++++++++
 tb/tb_fpu_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arbiter_if.sv
// Requester, FPU and response signals of the shared-FPU issue arbiter.
// master = requesters + FPU side, slave = arbiter.
interface fpu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_rd;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_rd;
    logic        flush0;
    logic        flush1;
    logic        fpu_in_valid;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_result;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic [4:0]  rsp0_rd;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic [4:0]  rsp1_rd;
    logic        busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_rd,
        output req1_valid, req1_op, req1_a, req1_b, req1_rd,
        output flush0, flush1, fpu_result,
        input  req0_ready, req1_ready,
        input  fpu_in_valid, fpu_op, fpu_a, fpu_b,
        input  rsp0_valid, rsp0_data, rsp0_rd,
        input  rsp1_valid, rsp1_data, rsp1_rd, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_rd,
        input  req1_valid, req1_op, req1_a, req1_b, req1_rd,
        input  flush0, flush1, fpu_result,
        output req0_ready, req1_ready,
        output fpu_in_valid, fpu_op, fpu_a, fpu_b,
        output rsp0_valid, rsp0_data, rsp0_rd,
        output rsp1_valid, rsp1_data, rsp1_rd, busy
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin issue arbiter and owner/rd tracker for a shared pipelined FPU.
// Latency: operands registered on accept; result returned LATENCY+1 edges after accept.
// Backpressure: ready is combinational grant; responses are strobes with no backpressure.
module fpu_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic         CLK,
    input  logic         reset,
    fpu_arbiter_if.slave bus
);
    typedef struct packed {
        logic       vld;
        logic       owner;
        logic [4:0] rd;
    } trk_t;

    trk_t        stage [0:LATENCY];
    trk_t        issue;
    trk_t        tail;
    logic        last_grant;
    logic        ready0;
    logic        ready1;
    logic        hs;
    logic        busy_any;
    logic        fpu_in_valid_q;
    logic [3:0]  fpu_op_q;
    logic [31:0] fpu_a_q;
    logic [31:0] fpu_b_q;
    logic        rsp0_valid_q;
    logic [31:0] rsp0_data_q;
    logic [4:0]  rsp0_rd_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp1_data_q;
    logic [4:0]  rsp1_rd_q;

    // A flushed owner's entry is dropped as it moves, so the tail capture sees it too.
    function automatic trk_t scrub(trk_t t, logic f0, logic f1);
        trk_t r;
        r = t;
        if ((t.owner && f1) || (!t.owner && f0)) r.vld = 1'b0;
        return r;
    endfunction

    always_comb begin
        ready0 = bus.req0_valid && !bus.flush0 &&
                 (!bus.req1_valid || bus.flush1 || last_grant);
        ready1 = bus.req1_valid && !bus.flush1 &&
                 (!bus.req0_valid || bus.flush0 || !last_grant);
        hs     = ready0 || ready1;
        issue.vld   = hs;
        issue.owner = ready1;
        issue.rd    = ready1 ? bus.req1_rd : bus.req0_rd;
        tail   = scrub(stage[LATENCY], bus.flush0, bus.flush1);
        busy_any = 1'b0;
        for (int i = 0; i <= LATENCY; i++) busy_any = busy_any | stage[i].vld;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= LATENCY; i++) stage[i] <= '0;
            last_grant     <= 1'b1;
            fpu_in_valid_q <= 1'b0;
            fpu_op_q       <= '0;
            fpu_a_q        <= '0;
            fpu_b_q        <= '0;
            rsp0_valid_q   <= 1'b0;
            rsp0_data_q    <= '0;
            rsp0_rd_q      <= '0;
            rsp1_valid_q   <= 1'b0;
            rsp1_data_q    <= '0;
            rsp1_rd_q      <= '0;
        end else begin
            stage[0] <= issue;
            for (int i = 1; i <= LATENCY; i++)
                stage[i] <= scrub(stage[i-1], bus.flush0, bus.flush1);
            fpu_in_valid_q <= hs;
            if (hs) begin
                last_grant <= ready1;
                fpu_op_q   <= ready1 ? bus.req1_op : bus.req0_op;
                fpu_a_q    <= ready1 ? bus.req1_a  : bus.req0_a;
                fpu_b_q    <= ready1 ? bus.req1_b  : bus.req0_b;
            end
            rsp0_valid_q <= tail.vld && !tail.owner;
            rsp1_valid_q <= tail.vld && tail.owner;
            if (tail.vld && !tail.owner) begin
                rsp0_data_q <= bus.fpu_result;
                rsp0_rd_q   <= tail.rd;
            end
            if (tail.vld && tail.owner) begin
                rsp1_data_q <= bus.fpu_result;
                rsp1_rd_q   <= tail.rd;
            end
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.fpu_in_valid = fpu_in_valid_q;
    assign bus.fpu_op       = fpu_op_q;
    assign bus.fpu_a        = fpu_a_q;
    assign bus.fpu_b        = fpu_b_q;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp0_data    = rsp0_data_q;
    assign bus.rsp0_rd      = rsp0_rd_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp1_data    = rsp1_data_q;
    assign bus.rsp1_rd      = rsp1_rd_q;
    assign bus.busy         = busy_any;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: a transaction-level model predicts grants and
// responses; a negedge monitor compares every cycle.
module tb_fpu_arbiter;
    localparam int L = 4;

    typedef struct {
        int          k;      // cycle in which operands sit on the FPU inputs
        int          due;    // cycle in which the response strobe is visible
        bit          owner;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    fpu_arbiter_if bus ();

    fpu_arbiter #(.LATENCY(L)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          model_last = 1'b1;
    bit          exp_rdy0 = 1'b0;
    bit          exp_rdy1 = 1'b0;
    ent_t        inflight [$];
    bit          plan_vld = 1'b0;
    ent_t        plan_ent;
    bit          plan_f0 = 1'b0;
    bit          plan_f1 = 1'b0;
    logic [31:0] res_hist [0:4095];
    bit          fx_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: commit the previous plan to the model, then drive new inputs and plan the next edge.
    task automatic step(input bit v0, input bit v1, input bit f0, input bit f1);
        bit g0, g1;
        @(posedge CLK);
        cyc++;
        for (int i = inflight.size() - 1; i >= 0; i--)
            if ((inflight[i].owner && plan_f1) || (!inflight[i].owner && plan_f0))
                inflight.delete(i);
        if (plan_vld) begin
            inflight.push_back(plan_ent);
            model_last = plan_ent.owner;
        end
        plan_vld = 1'b0;
        #1;
        bus.req0_valid = v0;
        bus.req0_op    = fx_en ? 4'h2 : 4'($urandom);
        bus.req0_a     = fx_en ? 32'h3F800000 : $urandom;
        bus.req0_b     = fx_en ? 32'h40000000 : $urandom;
        bus.req0_rd    = fx_en ? 5'd7 : 5'($urandom);
        bus.req1_valid = v1;
        bus.req1_op    = 4'($urandom);
        bus.req1_a     = $urandom;
        bus.req1_b     = $urandom;
        bus.req1_rd    = 5'($urandom);
        bus.flush0     = f0;
        bus.flush1     = f1;
        bus.fpu_result = $urandom;
        res_hist[cyc]  = bus.fpu_result;
        g0 = v0 && !f0;
        g1 = v1 && !f1;
        if (g0 && g1) begin
            if (model_last) g1 = 1'b0;
            else g0 = 1'b0;
        end
        exp_rdy0 = g0;
        exp_rdy1 = g1;
        if (g0 || g1) begin
            plan_vld       = 1'b1;
            plan_ent.k     = cyc + 1;
            plan_ent.due   = cyc + 2 + L;
            plan_ent.owner = g1;
            plan_ent.rd    = g1 ? bus.req1_rd : bus.req0_rd;
            plan_ent.op    = g1 ? bus.req1_op : bus.req0_op;
            plan_ent.a     = g1 ? bus.req1_a  : bus.req0_a;
            plan_ent.b     = g1 ? bus.req1_b  : bus.req0_b;
        end
        plan_f0 = f0;
        plan_f1 = f1;
        chk_en  = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge CLK) begin
        bit   ef, e0, e1, eb;
        ent_t fe, r0, r1;
        if (chk_en) begin
            ef = 1'b0; e0 = 1'b0; e1 = 1'b0; eb = 1'b0;
            foreach (inflight[i]) begin
                if (inflight[i].k == cyc) begin ef = 1'b1; fe = inflight[i]; end
                if (inflight[i].due == cyc) begin
                    if (inflight[i].owner) begin e1 = 1'b1; r1 = inflight[i]; end
                    else begin e0 = 1'b1; r0 = inflight[i]; end
                end
                if (inflight[i].k <= cyc && inflight[i].due > cyc) eb = 1'b1;
            end
            chk("req0_ready", bus.req0_ready, exp_rdy0);
            chk("req1_ready", bus.req1_ready, exp_rdy1);
            chk("fpu_in_valid", bus.fpu_in_valid, ef);
            if (ef) begin
                chk("fpu_op", bus.fpu_op, fe.op);
                chk("fpu_a", bus.fpu_a, fe.a);
                chk("fpu_b", bus.fpu_b, fe.b);
            end
            chk("rsp0_valid", bus.rsp0_valid, e0);
            if (e0) begin
                chk("rsp0_data", bus.rsp0_data, res_hist[r0.due - 1]);
                chk("rsp0_rd", bus.rsp0_rd, r0.rd);
            end
            chk("rsp1_valid", bus.rsp1_valid, e1);
            if (e1) begin
                chk("rsp1_data", bus.rsp1_data, res_hist[r1.due - 1]);
                chk("rsp1_rd", bus.rsp1_rd, r1.rd);
            end
            chk("busy", bus.busy, eb);
            for (int i = inflight.size() - 1; i >= 0; i--)
                if (inflight[i].due == cyc) inflight.delete(i);
        end
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_rd = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_rd = '0;
        bus.flush0 = 1'b0; bus.flush1 = 1'b0; bus.fpu_result = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        chk("rst_fpu_in_valid", bus.fpu_in_valid, 1'b0);
        chk("rst_fpu_op", bus.fpu_op, 4'h0);
        chk("rst_fpu_a", bus.fpu_a, 32'h0);
        chk("rst_fpu_b", bus.fpu_b, 32'h0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rst_rsp0_data", bus.rsp0_data, 32'h0);
        chk("rst_rsp0_rd", bus.rsp0_rd, 5'd0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_rsp1_data", bus.rsp1_data, 32'h0);
        chk("rst_rsp1_rd", bus.rsp1_rd, 5'd0);
        chk("rst_busy", bus.busy, 1'b0);
        repeat (2) begin @(posedge CLK); cyc++; end
        @(negedge CLK) reset = 1'b1;

        // single req0 operation with fixed operands
        fx_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        fx_en = 1'b0;
        idle(L + 4);

        // both contend for 6 cycles
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(L + 4);

        // req1 alone back-to-back
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(L + 4);

        // issue 0,1,0 then flush0 two edges after the last issue
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(L + 4);

        // flush1 against a pending req1 issue and a req1 tail entry
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(L);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(L + 4);

        // random traffic with occasional and simultaneous flushes
        for (int n = 0; n < 300; n++)
            step($urandom_range(3) != 0, $urandom_range(3) != 0,
                 $urandom_range(15) == 0, $urandom_range(15) == 0);
        idle(L + 4);

        // asynchronous reset with three operations in flight
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        cyc++;
        #2 reset = 1'b0;
        chk_en = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("arst_fpu_in_valid", bus.fpu_in_valid, 1'b0);
        chk("arst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("arst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        inflight.delete();
        plan_vld = 1'b0; plan_f0 = 1'b0; plan_f1 = 1'b0;
        model_last = 1'b1;
        repeat (2) begin @(posedge CLK); cyc++; end
        @(negedge CLK) reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(L + 6);

        chk("drain_empty", inflight.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
